// File: rtl/lrn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lrn_pkg
// Description : Shared widths and saturation limits for the LRN LUT scaler.
// Revision    : 1.0 - initial release
// ============================================================================
package lrn_pkg;

    localparam int c_DATA_WIDTH = 16;
    localparam int c_ADDR_WIDTH = 6;
    localparam int c_SQ_WIDTH   = 32;
    localparam int c_SQ_SHIFT   = 8;
    localparam int c_FRAC_BITS  = 14;

    // Largest positive value representable in a dw-bit two's complement word.
    function automatic longint max_pos(input int dw);
        return (longint'(1) << (dw - 1)) - longint'(1);
    endfunction

    // Most negative value representable in a dw-bit two's complement word.
    function automatic longint max_neg(input int dw);
        return -(longint'(1) << (dw - 1));
    endfunction

    localparam longint c_MAX_POS = max_pos(c_DATA_WIDTH);
    localparam longint c_MAX_NEG = max_neg(c_DATA_WIDTH);

endpackage
`default_nettype wire

// File: rtl/lrn_sat_mul.sv
`default_nettype none
// ============================================================================
// Module      : lrn_sat_mul
// Description : Signed activation x unsigned fixed-point scale, arithmetic
//               right shift (floor) and clip to the signed output range.
// Revision    : 1.0 - initial release
// ============================================================================
module lrn_sat_mul
    import lrn_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int FRAC_BITS  = c_FRAC_BITS
) (
    input  logic signed [DATA_WIDTH-1:0] data,
    input  logic        [DATA_WIDTH-1:0] scale,
    output logic signed [DATA_WIDTH-1:0] result,
    output logic                         sat
);

    // One extra bit so the unsigned scale can be carried as a positive signed operand.
    localparam int PW = 2 * DATA_WIDTH + 1;

    localparam logic signed [PW-1:0] c_LIM_POS = PW'(max_pos(DATA_WIDTH));
    localparam logic signed [PW-1:0] c_LIM_NEG = PW'(max_neg(DATA_WIDTH));

    logic signed [PW-1:0] w_data_ext;
    logic signed [PW-1:0] w_scale_ext;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_shift;

    assign w_data_ext  = PW'(data);
    assign w_scale_ext = PW'(scale);
    assign w_prod      = w_data_ext * w_scale_ext;
    assign w_shift     = w_prod >>> FRAC_BITS;

    // Clip the floored product into the output range and flag any clipping.
    always_comb begin
        result = w_shift[DATA_WIDTH-1:0];
        sat    = 1'b0;
        if (w_shift > c_LIM_POS) begin
            result = c_LIM_POS[DATA_WIDTH-1:0];
            sat    = 1'b1;
        end else if (w_shift < c_LIM_NEG) begin
            result = c_LIM_NEG[DATA_WIDTH-1:0];
            sat    = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lrn_lut_scaler.sv
`default_nettype none
// ============================================================================
// Module      : lrn_lut_scaler
// Description : Two-stage valid/ready pipeline that addresses the LRN scale
//               LUT from the sum-of-squares, aligns the registered ROM word
//               with the held activation and emits the saturated product.
// Revision    : 1.0 - initial release
// ============================================================================
module lrn_lut_scaler
    import lrn_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int SQ_WIDTH   = c_SQ_WIDTH,
    parameter int SQ_SHIFT   = c_SQ_SHIFT,
    parameter int FRAC_BITS  = c_FRAC_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic        [SQ_WIDTH-1:0]   in_sqsum,
    output logic        [ADDR_WIDTH-1:0] rom_address,
    output logic                         rom_enable,
    input  logic        [DATA_WIDTH-1:0] rom_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_sat
);

    localparam logic [SQ_WIDTH-1:0] c_ADDR_MAX = SQ_WIDTH'((1 << ADDR_WIDTH) - 1);

    logic                         r_s1_valid;
    logic signed [DATA_WIDTH-1:0] r_s1_data;
    logic                         w_advance2;
    logic                         w_accept;
    logic        [SQ_WIDTH-1:0]   w_idx;
    logic signed [DATA_WIDTH-1:0] w_result;
    logic                         w_sat;

    // s1 may only take a new sample (and thus a new ROM read) when it is empty
    // or draining this edge, so the held ROM word always belongs to s1.
    assign w_advance2 = !out_valid || out_ready;
    assign in_ready   = reset && (!r_s1_valid || w_advance2);
    assign w_accept   = in_valid && in_ready;
    assign rom_enable = w_accept;
    assign w_idx      = in_sqsum >> SQ_SHIFT;

    // Saturating LUT index; forced to zero while held in reset.
    always_comb begin
        rom_address = '0;
        if (reset) begin
            rom_address = (w_idx > c_ADDR_MAX) ? '1 : w_idx[ADDR_WIDTH-1:0];
        end
    end

    lrn_sat_mul #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_sat_mul (
        .data   (r_s1_data),
        .scale  (rom_data),
        .result (w_result),
        .sat    (w_sat)
    );

    // Stage 1: hold the activation while the ROM read completes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= in_data;
        end else if (w_advance2) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (w_advance2) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_data <= w_result;
                out_sat  <= w_sat;
            end
        end
    end

endmodule
`default_nettype wire
